vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-mode VGA timing generator.
- Generates hcount/vcount, hsync/vsync and hblnk/vblnk for any mode set by parameters.
- Adds configurable sync polarity, a pixel clock-enable, and single-cycle line_start/frame_start strobes.
- Sits at the head of the video pipeline; every downstream draw stage consumes its outputs.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, hsync asserted level (1 = active-high)
- VSYNC_POL, 1, vsync asserted level (1 = active-high)
- CNT_W, 11, counter width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock (40 MHz for the default mode)
- rst  in  1  synchronous reset, active-low (0 = reset)
- en  in  1  pixel clock-enable; counters advance only when en=1
- hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
- vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level set by HSYNC_POL
- vsync  out  1  vertical sync, level set by VSYNC_POL
- hblnk  out  1  1 outside the horizontal active region
- vblnk  out  1  1 outside the vertical active region
- line_start  out  1  1-cycle strobe on the cycle hcount becomes 0
- frame_start  out  1  1-cycle strobe on the cycle hcount and vcount both become 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628)
  - HS_START = H_ACTIVE+H_FP, HS_END = HS_START+H_SYNC-1
  - VS_START and VS_END are defined the same way from the vertical parameters.
- All outputs are registered. Decode is computed from the next-count values, so every output is aligned with the hcount/vcount presented in the same cycle (zero relative latency).
- Reset (rst=0 at posedge clk):
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL
  - line_start=0, frame_start=0
- Counting (en=1):
  - hcount increments by 1.
  - At hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount==V_TOTAL-1 on a line wrap, vcount wraps to 0.
- en=0: every output holds its value. line_start and frame_start are forced to 0, so a strobe is never repeated while en is low.
- Decode:
  - hblnk = (hcount >= H_ACTIVE)
  - vblnk = (vcount >= V_ACTIVE)
  - hsync = HSYNC_POL when HS_START <= hcount <= HS_END, otherwise !HSYNC_POL; vsync follows the same rule with the vertical constants.
  - vsync is evaluated per line; it changes only when hcount wraps to 0.
- Strobes:
  - line_start=1 for exactly one cycle when en=1 and hcount wraps to 0.
  - frame_start=1 for exactly one cycle when line_start=1 and vcount wraps to 0.
  - No strobes are produced on the first cycle after reset release.
- Boundaries:
  - Reset has priority over en. Reset asserted mid-frame returns the block to the reset state on the next clock edge.
  - No counter value is ever >= its TOTAL.
  - Degenerate mode (any porch = 0) must still produce correct windows, with no off-by-one against HS_START.
  - Elaboration must $error if CNT_W is too narrow or if H_SYNC or V_SYNC is 0.

Optional Feature:
- Macro: VGA_TIMING_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0].
  - frame_cnt resets to 0, increments on every frame_start, and wraps 65535 -> 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; rst=0 for 3 cycles, then en=1 continuously -> hcount counts 0..1055 and wraps; vcount wraps at 627; first frame_start one frame (663168 cycles) after the first count.
- Defaults -> hsync=1 exactly for hcount 840..967 and hblnk=1 exactly for hcount 800..1055; vsync=1 exactly for vcount 601..604 and vblnk=1 exactly for vcount 600..627.
- HSYNC_POL=0, VSYNC_POL=0 -> hsync=0 only for hcount 840..967; vsync=0 only for vcount 601..604; both are 1 during reset.
- en toggling 1,0,0,1 -> counts advance only on en=1 cycles; line_start stays high for exactly one cycle across the en=0 gap.
- Assert rst=0 at hcount=500, vcount=300 -> next cycle all outputs equal their reset values; counting restarts from 0,0.
- Macro defined, 3 frames run -> frame_cnt reads 0,1,2,3 with each increment coinciding with frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. It produces pixel/line counters,
// sync pulses with selectable polarity, blanking flags and one-cycle
// line/frame start strobes for any video mode described by the parameters.
// It sits at the head of the video pipeline, so every downstream draw stage
// relies on these outputs being mutually aligned.
//
// Ports:
//   clk          in   system clock (40 MHz for the default 800x600 mode)
//   rst          in   synchronous reset, active-low (0 = reset)
//   en           in   pixel clock-enable; counters advance only when en=1
//   hcount       out  horizontal position, 0..H_TOTAL-1
//   vcount       out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted level set by HSYNC_POL
//   vsync        out  vertical sync, asserted level set by VSYNC_POL
//   hblnk        out  1 outside the horizontal active region
//   vblnk        out  1 outside the vertical active region
//   line_start   out  1-cycle strobe on the cycle hcount becomes 0
//   frame_start  out  1-cycle strobe on the cycle hcount and vcount become 0
//   frame_cnt    out  [15:0] frame counter (only with the macro below)
//
// Optional feature macro: VGA_TIMING_GEN_FRAME_CNT_EN
//   When defined, adds frame_cnt[15:0]: reset to 0, +1 on every frame_start,
//   wrapping 65535 -> 0. When undefined the port and its logic are absent.
//
// Timing note: every output is a register loaded from values decoded from
// the *next* counter values, so all outputs describe the same (hcount,
// vcount) pair that is visible in the same cycle.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  // -------------------------------------------------------------------------
  // Derived mode constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam longint CNT_RANGE = longint'(1) << CNT_W;

  // Counter-width versions of the boundaries so every compare is width-exact.
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(VS_END);

  // Asserted sync levels; the idle level is simply the inverse.
  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity checks
  // -------------------------------------------------------------------------
  generate
    if (longint'(H_TOTAL) > CNT_RANGE) begin : g_err_h_width
      $error("vga_timing_gen: CNT_W=%0d too narrow for H_TOTAL=%0d", CNT_W, H_TOTAL);
    end
    if (longint'(V_TOTAL) > CNT_RANGE) begin : g_err_v_width
      $error("vga_timing_gen: CNT_W=%0d too narrow for V_TOTAL=%0d", CNT_W, V_TOTAL);
    end
    if (H_SYNC == 0) begin : g_err_h_sync
      $error("vga_timing_gen: H_SYNC must be non-zero");
    end
    if (V_SYNC == 0) begin : g_err_v_sync
      $error("vga_timing_gen: V_SYNC must be non-zero");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] hcount_reg, hcount_next;
  logic [CNT_W-1:0] vcount_reg, vcount_next;
  logic             hsync_reg,  hsync_next;
  logic             vsync_reg,  vsync_next;
  logic             hblnk_reg,  hblnk_next;
  logic             vblnk_reg,  vblnk_next;
  logic             line_start_reg;
  logic             frame_start_reg;

  logic             h_wrap;
  logic             v_wrap;

  // -------------------------------------------------------------------------
  // Next-count and decode
  // -------------------------------------------------------------------------
  always_comb begin
    h_wrap      = (hcount_reg == H_LAST_C);
    v_wrap      = (vcount_reg == V_LAST_C);

    hcount_next = h_wrap ? '0 : hcount_reg + 1'b1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = v_wrap ? '0 : vcount_reg + 1'b1;
    end

    // Windows are inclusive on both ends, so a zero front porch places the
    // sync start directly on the first blanked pixel with no gap.
    hblnk_next = (hcount_next >= H_ACT_C);
    vblnk_next = (vcount_next >= V_ACT_C);
    hsync_next = ((hcount_next >= HS_START_C) && (hcount_next <= HS_END_C)) ? HS_ON : ~HS_ON;

    // vsync is a per-line signal: it is only re-evaluated on a line wrap.
    vsync_next = vsync_reg;
    if (h_wrap) begin
      vsync_next = ((vcount_next >= VS_START_C) && (vcount_next <= VS_END_C)) ? VS_ON : ~VS_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      hsync_reg       <= ~HS_ON;
      vsync_reg       <= ~VS_ON;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (en) begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hblnk_reg       <= hblnk_next;
      vblnk_reg       <= vblnk_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      line_start_reg  <= h_wrap;
      frame_start_reg <= h_wrap && v_wrap;
    end else begin
      // Hold everything, but drop the strobes so a stalled pixel clock never
      // replays a line or frame start.
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  // -------------------------------------------------------------------------
  // Optional frame counter, advancing on the same edge frame_start rises.
  // -------------------------------------------------------------------------
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_reg <= '0;
    end else if (en && h_wrap && v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign hblnk       = hblnk_reg;
  assign vblnk       = vblnk_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two small instances share clk/rst/en:
//   A: 16x8 total (active 8x4), hsync 10..12, vsync lines 5..6, active-high
//   B: 8x4 total (active 6x3), zero porches, hsync 6..7, vsync line 3,
//      active-low, CNT_W=3 (counter exactly as wide as needed)
// A reference position model is advanced alongside the DUT and all outputs
// are compared every cycle against hand-computed windows; directed checks
// cover reset, en gaps, mid-frame reset and frame timing.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  logic [4:0] hcount_a, vcount_a;
  logic       hsync_a, vsync_a, hblnk_a, vblnk_a, line_start_a, frame_start_a;
  logic [2:0] hcount_b, vcount_b;
  logic       hsync_b, vsync_b, hblnk_b, vblnk_b, line_start_b, frame_start_b;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_a, frame_cnt_b;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(5)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount_a), .vcount(vcount_a),
    .hsync(hsync_a), .vsync(vsync_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(0), .H_SYNC(2), .H_BP(0),
    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0),
    .HSYNC_POL(0), .VSYNC_POL(0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   ah, av, bh, bv, afc, bfc;
  logic als, afs, bls, bfs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    // Instance A: active-high syncs
    check_eq("A.hcount", 32'(hcount_a), ah);
    check_eq("A.vcount", 32'(vcount_a), av);
    check_eq("A.hblnk", 32'(hblnk_a), (ah >= 8) ? 1 : 0);
    check_eq("A.vblnk", 32'(vblnk_a), (av >= 4) ? 1 : 0);
    check_eq("A.hsync", 32'(hsync_a), (ah >= 10 && ah <= 12) ? 1 : 0);
    check_eq("A.vsync", 32'(vsync_a), (av >= 5 && av <= 6) ? 1 : 0);
    check_eq("A.line_start", 32'(line_start_a), 32'(als));
    check_eq("A.frame_start", 32'(frame_start_a), 32'(afs));
    // Instance B: active-low syncs, zero porches
    check_eq("B.hcount", 32'(hcount_b), bh);
    check_eq("B.vcount", 32'(vcount_b), bv);
    check_eq("B.hblnk", 32'(hblnk_b), (bh >= 6) ? 1 : 0);
    check_eq("B.vblnk", 32'(vblnk_b), (bv >= 3) ? 1 : 0);
    check_eq("B.hsync", 32'(hsync_b), (bh >= 6) ? 0 : 1);
    check_eq("B.vsync", 32'(vsync_b), (bv == 3) ? 0 : 1);
    check_eq("B.line_start", 32'(line_start_b), 32'(bls));
    check_eq("B.frame_start", 32'(frame_start_b), 32'(bfs));
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    check_eq("A.frame_cnt", 32'(frame_cnt_a), afc);
    check_eq("B.frame_cnt", 32'(frame_cnt_b), bfc);
`endif
  endtask

  // Apply one clock with the given inputs, advance the model, compare.
  task automatic tick(input logic r, input logic e);
    rst = r;
    en  = e;
    @(posedge clk);
    if (!r) begin
      ah = 0; av = 0; bh = 0; bv = 0; afc = 0; bfc = 0;
      als = 0; afs = 0; bls = 0; bfs = 0;
    end else if (e) begin
      als = (ah == 15);
      afs = als && (av == 7);
      ah  = als ? 0 : ah + 1;
      if (als) av = (av == 7) ? 0 : av + 1;
      if (afs) afc = (afc + 1) % 65536;
      bls = (bh == 7);
      bfs = bls && (bv == 3);
      bh  = bls ? 0 : bh + 1;
      if (bls) bv = (bv == 3) ? 0 : bv + 1;
      if (bfs) bfc = (bfc + 1) % 65536;
    end else begin
      als = 0; afs = 0; bls = 0; bfs = 0;
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int hs_hi, hb_hi, vs_hi, vb_hi, ls_n, hs_lo_b, vs_lo_b;
    int fa_idx, fb_idx, guard, fs_seen;

    ah = 0; av = 0; bh = 0; bv = 0; afc = 0; bfc = 0;
    als = 0; afs = 0; bls = 0; bfs = 0;

    // ---- Reset, with en=1 on one reset cycle to show reset priority ----
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check_eq("rst.A.hsync", 32'(hsync_a), 0);
    check_eq("rst.A.vsync", 32'(vsync_a), 0);
    check_eq("rst.B.hsync", 32'(hsync_b), 1);
    check_eq("rst.B.vsync", 32'(vsync_b), 1);
    check_eq("rst.A.hcount", 32'(hcount_a), 0);
    check_eq("rst.A.hblnk", 32'(hblnk_a), 0);
    $display("[tb] reset: hcount=%0d vcount=%0d hsync=%0d vsync=%0d", hcount_a, vcount_a, hsync_a, vsync_a);

    // ---- Continuous counting: one full frame of A, first frame timing ----
    hs_hi = 0; hb_hi = 0; vs_hi = 0; vb_hi = 0; ls_n = 0;
    hs_lo_b = 0; vs_lo_b = 0; fa_idx = 0; fb_idx = 0;
    for (int i = 0; i < 128; i++) begin
      tick(1'b1, 1'b1);
      if (i == 0) begin
        check_eq("first.A.hcount", 32'(hcount_a), 1);
        check_eq("first.A.line_start", 32'(line_start_a), 0);
      end
      hs_hi += int'(hsync_a);
      hb_hi += int'(hblnk_a);
      vs_hi += int'(vsync_a);
      vb_hi += int'(vblnk_a);
      ls_n  += int'(line_start_a);
      if (i < 32) begin
        hs_lo_b += int'(!hsync_b);
        vs_lo_b += int'(!vsync_b);
      end
      if (frame_start_a && fa_idx == 0) fa_idx = i + 1;
      if (frame_start_b && fb_idx == 0) fb_idx = i + 1;
    end
    check_eq("frame.A.first_fs", fa_idx, 128);
    check_eq("frame.B.first_fs", fb_idx, 32);
    check_eq("frame.A.hsync_cycles", hs_hi, 24);
    check_eq("frame.A.hblnk_cycles", hb_hi, 64);
    check_eq("frame.A.vsync_cycles", vs_hi, 32);
    check_eq("frame.A.vblnk_cycles", vb_hi, 64);
    check_eq("frame.A.line_starts", ls_n, 8);
    check_eq("frame.B.hsync_low", hs_lo_b, 8);
    check_eq("frame.B.vsync_low", vs_lo_b, 8);
    $display("[tb] frame1: first_fs A=%0d B=%0d hsync=%0d hblnk=%0d vsync=%0d vblnk=%0d",
             fa_idx, fb_idx, hs_hi, hb_hi, vs_hi, vb_hi);

    // Keep running across further wraps with the per-cycle model check.
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b1);
    $display("[tb] sweep: 200 more cycles, at hcount=%0d vcount=%0d", hcount_a, vcount_a);

    // ---- en pattern 1,0,0,1 across a line wrap ----
    guard = 0;
    while (ah != 15 && guard < 100) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check_eq("align.en_gap.in_budget", (guard < 100) ? 1 : 0, 1);
    ls_n = 0;
    tick(1'b1, 1'b1);
    check_eq("gap.1.hcount", 32'(hcount_a), 0);
    check_eq("gap.1.line_start", 32'(line_start_a), 1);
    ls_n += int'(line_start_a);
    tick(1'b1, 1'b0);
    check_eq("gap.2.hcount", 32'(hcount_a), 0);
    check_eq("gap.2.line_start", 32'(line_start_a), 0);
    ls_n += int'(line_start_a);
    tick(1'b1, 1'b0);
    check_eq("gap.3.hcount", 32'(hcount_a), 0);
    ls_n += int'(line_start_a);
    tick(1'b1, 1'b1);
    check_eq("gap.4.hcount", 32'(hcount_a), 1);
    ls_n += int'(line_start_a);
    check_eq("gap.line_start_total", ls_n, 1);
    $display("[tb] en 1,0,0,1: line_start pulses=%0d hcount=%0d", ls_n, hcount_a);

    // ---- Mid-frame reset at hcount=5, vcount=3 ----
    guard = 0;
    while (!(ah == 5 && av == 3) && guard < 200) begin
      tick(1'b1, 1'b1);
      guard++;
    end
    check_eq("align.midrst.in_budget", (guard < 200) ? 1 : 0, 1);
    check_eq("midrst.pre.hcount", 32'(hcount_a), 5);
    check_eq("midrst.pre.vcount", 32'(vcount_a), 3);
    tick(1'b0, 1'b1);
    check_eq("midrst.A.hcount", 32'(hcount_a), 0);
    check_eq("midrst.A.vcount", 32'(vcount_a), 0);
    check_eq("midrst.A.hsync", 32'(hsync_a), 0);
    check_eq("midrst.B.vsync", 32'(vsync_b), 1);
    tick(1'b1, 1'b1);
    check_eq("midrst.restart.hcount", 32'(hcount_a), 1);
    check_eq("midrst.restart.vcount", 32'(vcount_a), 0);
    $display("[tb] mid-frame reset: restart hcount=%0d vcount=%0d", hcount_a, vcount_a);

    // ---- Three frames from reset release ----
    fs_seen = 0;
    for (int i = 0; i < 383; i++) begin
      tick(1'b1, 1'b1);
      fs_seen += int'(frame_start_a);
    end
    check_eq("frames3.A.frame_starts", fs_seen, 3);
    check_eq("frames3.A.at_origin", 32'({hcount_a, vcount_a}), 0);
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    check_eq("frames3.A.frame_cnt", 32'(frame_cnt_a), 3);
    check_eq("frames3.B.frame_cnt", 32'(frame_cnt_b), 12);
    $display("[tb] 3 frames: frame_starts=%0d frame_cnt A=%0d B=%0d", fs_seen, frame_cnt_a, frame_cnt_b);
`else
    $display("[tb] 3 frames: frame_starts=%0d", fs_seen);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
